automat_multi_produs: RTL

Parametrised coin-operated vending controller, successor to the single-product coffee FSM. It accepts three coin denominations and accumulates credit. It serves one of N_PROD products at individually configurable prices, then returns change one unit per cycle. Cancel and inactivity timeout refund the full credit. It sits between the coin/button front-end and the dispenser and change-hopper drivers.

---
 rtl/automat_multi_produs.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/automat_multi_produs.sv
// rtl/automat_multi_produs.sv - multi-product coin vending controller with change return
module automat_multi_produs #(
    parameter int                         N_PROD     = 4,
    parameter int                         CREDIT_W   = 5,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {5'd6, 5'd5, 5'd4, 5'd3},
    parameter int                         V1         = 1,
    parameter int                         V2         = 2,
    parameter int                         V3         = 5,
    parameter int                         MAX_CREDIT = 20,
    parameter int                         TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                B1,
    input  logic                B2,
    input  logic                B3,
    input  logic                sel,
    input  logic [2:0]          sel_id,
    input  logic                cancel,
    output logic                cafea,
    output logic [2:0]          cafea_id,
    output logic                rest,
    output logic                coin_rej,
    output logic                sel_err,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    // One extra bit so credit + coin can be compared against MAX_CREDIT without wrapping
    localparam int SW = CREDIT_W + 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_t;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [TW-1:0]       tmo, tmo_n;
    logic [2:0]          prod_id, prod_id_n;
    logic                cafea_n, rest_n, coin_rej_n, sel_err_n, busy_n;
    logic [2:0]          cafea_id_n;

    logic [CREDIT_W-1:0] price_tab [0:7];
    logic [1:0]          n_coins;
    logic                coin_any, coin_ok, sel_ok;
    logic [SW-1:0]       coin_val, sum;
    logic [CREDIT_W-1:0] price_sel;

    // Price lookup table; indices beyond N_PROD read as zero and are refused by sel_ok
    for (genvar k = 0; k < 8; k++) begin : g_price
        if (k < N_PROD) begin : g_used
            assign price_tab[k] = PRICES[k*CREDIT_W +: CREDIT_W];
        end else begin : g_unused
            assign price_tab[k] = '0;
        end
    end

    assign price_sel = price_tab[sel_id];
    assign sel_ok    = ({1'b0, sel_id} < 4'(N_PROD)) && (credit >= price_sel);
    assign n_coins   = {1'b0, B1} + {1'b0, B2} + {1'b0, B3};
    assign coin_any  = B1 | B2 | B3;

    // Value of the single inserted coin (only meaningful when exactly one is high)
    always_comb begin
        coin_val = SW'(V3);
        if (B1)
            coin_val = SW'(V1);
        else if (B2)
            coin_val = SW'(V2);
    end

    assign sum     = {1'b0, credit} + coin_val;
    assign coin_ok = (n_coins == 2'd1) && (sum <= SW'(MAX_CREDIT));

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_n    = state;
        credit_n   = credit;
        tmo_n      = tmo;
        prod_id_n  = prod_id;
        coin_rej_n = 1'b0;
        sel_err_n  = 1'b0;
        case (state)
            S_IDLE: begin
                tmo_n     = '0;
                sel_err_n = sel;
                if (coin_any) begin
                    if (coin_ok) begin
                        credit_n = sum[CREDIT_W-1:0];
                        state_n  = S_CREDIT;
                    end else begin
                        coin_rej_n = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    state_n    = S_CHANGE;
                    tmo_n      = '0;
                    coin_rej_n = coin_any;
                end else if (sel && sel_ok) begin
                    state_n    = S_VEND;
                    credit_n   = credit - price_sel;
                    prod_id_n  = sel_id;
                    tmo_n      = '0;
                    coin_rej_n = coin_any;
                end else begin
                    // A refused selection still lets a coin through in the same cycle
                    sel_err_n = sel;
                    if (coin_ok) begin
                        credit_n = sum[CREDIT_W-1:0];
                        tmo_n    = '0;
                    end else begin
                        coin_rej_n = coin_any;
                        if (sel) begin
                            tmo_n = '0;
                        end else if (tmo == TW'(TIMEOUT - 1)) begin
                            state_n = S_CHANGE;
                            tmo_n   = '0;
                        end else begin
                            tmo_n = tmo + TW'(1);
                        end
                    end
                end
            end
            S_VEND: begin
                coin_rej_n = coin_any;
                state_n    = (credit != '0) ? S_CHANGE : S_IDLE;
            end
            default: begin
                // S_CHANGE: the rest pulse shown this cycle pays out one unit at the edge
                coin_rej_n = coin_any;
                if (credit <= CREDIT_W'(1)) begin
                    credit_n = '0;
                    state_n  = S_IDLE;
                end else begin
                    credit_n = credit - CREDIT_W'(1);
                end
            end
        endcase
        cafea_n    = (state_n == S_VEND);
        cafea_id_n = (state_n == S_VEND) ? prod_id_n : 3'd0;
        rest_n     = (state_n == S_CHANGE);
        busy_n     = (state_n == S_VEND) || (state_n == S_CHANGE);
    end

    // State, credit, timeout and registered outputs; reset drops any pending change
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            credit   <= '0;
            tmo      <= '0;
            prod_id  <= 3'd0;
            cafea    <= 1'b0;
            cafea_id <= 3'd0;
            rest     <= 1'b0;
            coin_rej <= 1'b0;
            sel_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            tmo      <= tmo_n;
            prod_id  <= prod_id_n;
            cafea    <= cafea_n;
            cafea_id <= cafea_id_n;
            rest     <= rest_n;
            coin_rej <= coin_rej_n;
            sel_err  <= sel_err_n;
            busy     <= busy_n;
        end
    end

endmodule
